// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between MEM and the 16-word data memory.
// Loads own the single memory port; buffered stores retire only in cycles
// without a load. Loads forward from the youngest matching buffered store.

// One buffer slot's forwarding compare: the slot is live when its age
// (distance from head) is below count, and it hits when its word index
// matches the load's word index.
module store_buffer_slot #(
    parameter int SLOT  = 0,
    parameter int PTR_W = 2,
    parameter int CNT_W = 3,
    parameter int IDX_W = 4
) (
    input  logic [PTR_W-1:0] head,
    input  logic [CNT_W-1:0] count,
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] ld_idx,
    output logic             hit,
    output logic [PTR_W-1:0] age
);

    // age wraps modulo DEPTH because pointers are PTR_W bits wide
    always_comb begin
        age = PTR_W'(SLOT) - head;
        hit = (CNT_W'(age) < count) && (idx == ld_idx);
    end

endmodule

module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_wdata,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [31:0]       ld_rdata,
    output logic              stall,
    output logic              empty,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = ADDR_W - 2;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              drain;
    logic              accept;

    logic [DEPTH-1:0]  slot_hit;
    logic [PTR_W-1:0]  slot_age [DEPTH];
    logic              fwd_hit;
    logic [PTR_W-1:0]  fwd_age;
    logic [31:0]       fwd_data;

    // Byte-lane bits are meaningless at word granularity.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign full   = (count == CNT_W'(DEPTH));
    assign drain  = dmem_we;
    assign accept = st_valid && (!full || drain);
    assign stall  = st_valid && !accept;
    assign empty  = (count == '0);

    // Port arbitration: a load always wins; otherwise retire the head store.
    always_comb begin
        dmem_addr  = '0;
        dmem_we    = 1'b0;
        dmem_wdata = '0;
        if (ld_valid) begin
            dmem_addr = ld_addr;
        end else if (count != '0) begin
            dmem_addr  = {entries[head].idx, 2'b00};
            dmem_wdata = entries[head].data;
            dmem_we    = 1'b1;
        end
    end

    // Per-slot forwarding compares.
    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        store_buffer_slot #(
            .SLOT  (s),
            .PTR_W (PTR_W),
            .CNT_W (CNT_W),
            .IDX_W (IDX_W)
        ) u_slot (
            .head   (head),
            .count  (count),
            .idx    (entries[s].idx),
            .ld_idx (ld_addr[ADDR_W-1:2]),
            .hit    (slot_hit[s]),
            .age    (slot_age[s])
        );
    end

    // Pick the youngest hit (largest age); a miss falls through to memory.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_age  = '0;
        fwd_data = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (slot_hit[s] && (!fwd_hit || slot_age[s] > fwd_age)) begin
                fwd_hit  = 1'b1;
                fwd_age  = slot_age[s];
                fwd_data = entries[s].data;
            end
        end
        ld_rdata = fwd_hit ? fwd_data : dmem_rdata;
    end

    // FIFO state: drain pops head, accept pushes tail; both together keep count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            if (accept) begin
                entries[tail].idx  <= st_addr[ADDR_W-1:2];
                entries[tail].data <= st_wdata;
                tail               <= tail + PTR_W'(1);
            end
            if (accept && !drain) begin
                count <= count + CNT_W'(1);
            end else if (drain && !accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a decoupled scoreboard monitor.
// The stimulus pushes per-cycle expectations and expected memory writes;
// the monitor pops and compares on the falling edge.
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_wdata;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_rdata;
    logic              stall;
    logic              empty;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_we;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_wdata   (st_wdata),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_rdata   (ld_rdata),
        .stall      (stall),
        .empty      (empty),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    logic [31:0] mem [16];
    bit          mem_init;
    assign dmem_rdata = mem[dmem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (dmem_we === 1'b1) begin
            mem[dmem_addr[5:2]] <= dmem_wdata;
        end
    end

    typedef struct {
        bit          chk_ld;
        logic [31:0] exp_rd;
        bit          exp_stall;
        int          exp_empty;
        bit          chk_idle;
    } rec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } pend_t;

    rec_t  rec_q [$];
    wr_t   wr_q  [$];
    pend_t pend  [$];
    logic [31:0] shadow [16];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle expectations plus every memory write in order.
    rec_t mon_r;
    wr_t  mon_w;
    always @(negedge clk) begin
        if (rec_q.size() > 0) begin
            mon_r = rec_q.pop_front();
            chk("stall", 32'(stall), 32'(mon_r.exp_stall));
            if (mon_r.chk_ld) chk("ld_rdata", ld_rdata, mon_r.exp_rd);
            if (mon_r.exp_empty >= 0) chk("empty", 32'(empty), 32'(mon_r.exp_empty));
            if (mon_r.chk_idle) begin
                chk("idle_we", 32'(dmem_we), 32'd0);
                chk("idle_addr", 32'(dmem_addr), 32'd0);
                chk("idle_wdata", dmem_wdata, 32'd0);
            end
        end
        if (rst_n === 1'b1 && dmem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", dmem_addr, dmem_wdata);
            end else begin
                mon_w = wr_q.pop_front();
                chk("wr_addr", 32'(dmem_addr), 32'(mon_w.addr));
                chk("wr_data", dmem_wdata, mon_w.data);
            end
        end
    end

    function automatic logic [31:0] model_ld(input logic [5:0] la);
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].idx == la[5:2]) return pend[i].data;
        return shadow[la[5:2]];
    endfunction

    // One clock cycle of stimulus with its expectations.
    task automatic cyc(input bit sv, input logic [5:0] sa, input logic [31:0] sd,
                       input bit lv, input logic [5:0] la, input logic [31:0] erd,
                       input bit estall, input int eempty, input bit eidle);
        rec_t r;
        wr_t  w;
        pend_t p;
        bit dr;
        @(posedge clk); #1;
        st_valid = sv; st_addr = sa; st_wdata = sd;
        ld_valid = lv; ld_addr = la;
        r.chk_ld = lv; r.exp_rd = erd; r.exp_stall = estall;
        r.exp_empty = eempty; r.chk_idle = eidle;
        rec_q.push_back(r);
        if (sv && !estall) begin
            w.addr = {sa[5:2], 2'b00}; w.data = sd;
            wr_q.push_back(w);
        end
        dr = !lv && pend.size() > 0;
        if (dr) begin
            p = pend.pop_front();
            shadow[p.idx] = p.data;
        end
        if (sv && !estall) begin
            p.idx = sa[5:2]; p.data = sd;
            pend.push_back(p);
        end
    endtask

    task automatic cyc_model(input bit sv, input logic [5:0] sa, input logic [31:0] sd,
                             input bit lv, input logic [5:0] la);
        logic [31:0] erd;
        bit est;
        erd = model_ld(la);
        est = sv && lv && pend.size() == DEPTH;
        cyc(sv, sa, sd, lv, la, erd, est, -1, 1'b0);
    endtask

    task automatic idle(input int eempty);
        cyc(1'b0, 6'h0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b0, eempty, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st_valid = 0; st_addr = 0; st_wdata = 0;
        ld_valid = 0; ld_addr = 0;
        rst_n = 0; mem_init = 1;
        for (int i = 0; i < 16; i++) shadow[i] = 32'hC0DE_0000 + 32'(i);
        repeat (2) @(posedge clk);
        #1 rst_n = 1; mem_init = 0;

        // Reset state, single store retiring one cycle later
        cyc(0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 0, 1, 1);
        cyc(1, 6'h08, 32'hDEADBEEF, 0, 6'h00, 32'h0, 0, 1, 0);
        idle(0);
        cyc(0, 6'h00, 32'h0, 1, 6'h08, 32'hDEADBEEF, 0, 1, 0);

        // Fill under continuous loads, stall, then accept with drain
        cyc(1, 6'h00, 32'd1, 1, 6'h3C, 32'hC0DE000F, 0, 1, 0);
        cyc(1, 6'h04, 32'd2, 1, 6'h3C, 32'hC0DE000F, 0, 0, 0);
        cyc(1, 6'h08, 32'd3, 1, 6'h3C, 32'hC0DE000F, 0, 0, 0);
        cyc(1, 6'h0C, 32'd4, 1, 6'h3C, 32'hC0DE000F, 0, 0, 0);
        cyc(1, 6'h10, 32'd5, 1, 6'h3C, 32'hC0DE000F, 1, 0, 0);
        cyc(1, 6'h10, 32'd5, 0, 6'h00, 32'h0, 0, 0, 0);
        idle(0); idle(0); idle(0); idle(0); idle(1);

        // Forwarding picks the youngest match; byte bits ignored
        cyc(1, 6'h14, 32'h11, 1, 6'h3C, 32'hC0DE000F, 0, 1, 0);
        cyc(1, 6'h14, 32'h22, 1, 6'h3C, 32'hC0DE000F, 0, 0, 0);
        cyc(0, 6'h00, 32'h0, 1, 6'h14, 32'h22, 0, 0, 0);
        cyc(0, 6'h00, 32'h0, 1, 6'h17, 32'h22, 0, 0, 0);
        cyc(0, 6'h00, 32'h0, 1, 6'h18, 32'hC0DE0006, 0, 0, 0);
        idle(0); idle(0);
        cyc(0, 6'h00, 32'h0, 1, 6'h14, 32'h22, 0, 1, 0);

        // Same-cycle store and load: load sees old memory
        cyc(1, 6'h20, 32'hA5A5A5A5, 1, 6'h20, 32'hC0DE0008, 0, 1, 0);
        cyc(0, 6'h00, 32'h0, 1, 6'h20, 32'hA5A5A5A5, 0, 0, 0);
        idle(0);

        // Reset with three stores pending; they must never retire
        cyc(1, 6'h24, 32'h111, 1, 6'h3C, 32'hC0DE000F, 0, 1, 0);
        cyc(1, 6'h28, 32'h222, 1, 6'h3C, 32'hC0DE000F, 0, 0, 0);
        cyc(1, 6'h2C, 32'h333, 1, 6'h3C, 32'hC0DE000F, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 0; st_valid = 0; ld_valid = 1; ld_addr = 6'h3C;
        @(posedge clk); #1;
        rst_n = 1; ld_valid = 0;
        wr_q.delete();
        pend.delete();
        cyc(0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 0, 1, 1);
        cyc(0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 0, 1, 1);
        cyc(0, 6'h00, 32'h0, 1, 6'h24, 32'hC0DE0009, 0, 1, 0);

        // Wrap-around: alternating store+load and store+drain cycles
        for (int k = 0; k < 10; k++) begin
            logic [5:0] sa;
            logic [5:0] la;
            sa = 6'h30 + 6'(4 * (k % 4));
            la = (k == 0) ? 6'h3C : 6'h30 + 6'(4 * ((k - 1) % 4));
            cyc_model(1'b1, sa, 32'hB000 + 32'(k), (k % 2) == 0, la);
        end
        for (int k = 0; k < 5; k++) cyc_model(1'b0, 6'h0, 32'h0, 1'b0, 6'h0);
        for (int k = 0; k < 4; k++) cyc_model(1'b0, 6'h0, 32'h0, 1'b1, 6'h30 + 6'(4 * k));
        idle(1);

        @(posedge clk);
        @(negedge clk);
        chk("writes_outstanding", 32'(wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
